// File: rtl/pen_locator.sv
// rtl/pen_locator.sv - light-pen position decoder for the 8x8 matrix scan
module pen_locator #(
  parameter int HIT_CYCLES     = 8,
  parameter int BLANK_CYCLES   = 2,
  parameter int CONFIRM_FRAMES = 2,
  parameter int MISS_FRAMES    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       pen_n,
  input  logic       frame_start,
  input  logic       slot_strobe,
  input  logic [2:0] slot_row,
  input  logic [2:0] slot_col,
  output logic [2:0] pos_row,
  output logic [2:0] pos_col,
  output logic       pos_valid,
  output logic       pos_stb,
  output logic       pen_present
);

  localparam logic [7:0] HIT_L   = 8'(HIT_CYCLES);
  localparam logic [7:0] BLANK_L = 8'(BLANK_CYCLES);
  localparam logic [3:0] CONF_L  = 4'(CONFIRM_FRAMES);
  localparam logic [3:0] MISS_L  = 4'(MISS_FRAMES);

  typedef enum logic [1:0] {S_IDLE, S_ACQUIRE, S_TRACK} state_t;

  logic       r_pen_meta, r_pen_sync;
  logic       w_pen;
  logic [2:0] r_cur_r, r_cur_c;
  logic [7:0] r_run, r_blank;
  logic       w_blank_act, w_run_inc, w_hit_now;
  logic       r_frame_hit;
  logic [2:0] r_hit_r, r_hit_c;

  state_t     r_state, w_state_nx;
  logic [2:0] r_cand_r, r_cand_c, w_cand_r_nx, w_cand_c_nx;
  logic [3:0] r_confirm, r_miss, w_confirm_nx, w_miss_nx;
  logic [2:0] r_pos_r, r_pos_c, w_pos_r_nx, w_pos_c_nx;
  logic       r_stb, w_stb_nx;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Two-flop synchronizer on the raw sense line; idle level is high (no light)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pen_meta <= 1'b1;
      r_pen_sync <= 1'b1;
    end else begin
      r_pen_meta <= pen_n;
      r_pen_sync <= r_pen_meta;
    end
  end

  assign w_pen       = ~r_pen_sync;
  assign w_blank_act = (r_blank != 8'd0);
  // The strobe cycle itself never counts, so a hit can never land on a slot edge
  assign w_run_inc   = !slot_strobe && !w_blank_act && w_pen && (r_run != HIT_L);
  assign w_hit_now   = w_run_inc && ((r_run + 8'd1) == HIT_L);

  // Slot capture, post-strobe blanking and the consecutive pen-high run counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_r <= 3'd0;
      r_cur_c <= 3'd0;
      r_run   <= 8'd0;
      r_blank <= 8'd0;
    end else if (slot_strobe) begin
      r_cur_r <= slot_row;
      r_cur_c <= slot_col;
      r_run   <= 8'd0;
      r_blank <= BLANK_L;
    end else if (w_blank_act) begin
      r_blank <= r_blank - 8'd1;
      r_run   <= 8'd0;
    end else if (!w_pen) begin
      r_run <= 8'd0;
    end else if (w_run_inc) begin
      r_run <= r_run + 8'd1;
    end
  end

  // Latch the first qualifying slot of the frame; the boundary consumes and clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_hit <= 1'b0;
      r_hit_r     <= 3'd0;
      r_hit_c     <= 3'd0;
    end else if (frame_start) begin
      r_frame_hit <= 1'b0;
    end else if (w_hit_now && !r_frame_hit) begin
      r_frame_hit <= 1'b1;
      r_hit_r     <= r_cur_r;
      r_hit_c     <= r_cur_c;
    end
  end

  // Frame-level qualification: next state, candidate, counters and published position
  always_comb begin
    w_state_nx   = r_state;
    w_cand_r_nx  = r_cand_r;
    w_cand_c_nx  = r_cand_c;
    w_confirm_nx = r_confirm;
    w_miss_nx    = r_miss;
    w_pos_r_nx   = r_pos_r;
    w_pos_c_nx   = r_pos_c;
    w_stb_nx     = 1'b0;
    if (!en || r_state == S_IDLE) begin
      w_cand_r_nx  = 3'd0;
      w_cand_c_nx  = 3'd0;
      w_confirm_nx = 4'd0;
      w_miss_nx    = 4'd0;
      if (!en) begin
        w_state_nx = S_IDLE;
      end else if (frame_start) begin
        // Arming boundary: the partial frame before it is discarded
        w_state_nx = S_ACQUIRE;
      end
    end else if (frame_start) begin
      if (r_state == S_ACQUIRE) begin
        if (r_frame_hit) begin
          if (r_hit_r == r_cand_r && r_hit_c == r_cand_c) begin
            w_confirm_nx = sat_inc(r_confirm);
          end else begin
            w_cand_r_nx  = r_hit_r;
            w_cand_c_nx  = r_hit_c;
            w_confirm_nx = 4'd1;
          end
        end else begin
          w_confirm_nx = 4'd0;
        end
        if (w_confirm_nx >= CONF_L) begin
          w_pos_r_nx = w_cand_r_nx;
          w_pos_c_nx = w_cand_c_nx;
          w_stb_nx   = 1'b1;
          w_miss_nx  = 4'd0;
          w_state_nx = S_TRACK;
        end
      end else begin
        if (r_frame_hit) begin
          w_miss_nx = 4'd0;
          if (r_hit_r != r_pos_r || r_hit_c != r_pos_c) begin
            w_pos_r_nx = r_hit_r;
            w_pos_c_nx = r_hit_c;
            w_stb_nx   = 1'b1;
          end
        end else begin
          w_miss_nx = sat_inc(r_miss);
          if (w_miss_nx >= MISS_L) begin
            // Pen lost: position is kept on the outputs but no longer valid
            w_confirm_nx = 4'd0;
            w_state_nx   = S_ACQUIRE;
          end
        end
      end
    end
  end

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cand_r  <= 3'd0;
      r_cand_c  <= 3'd0;
      r_confirm <= 4'd0;
      r_miss    <= 4'd0;
      r_pos_r   <= 3'd0;
      r_pos_c   <= 3'd0;
      r_stb     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cand_r  <= w_cand_r_nx;
      r_cand_c  <= w_cand_c_nx;
      r_confirm <= w_confirm_nx;
      r_miss    <= w_miss_nx;
      r_pos_r   <= w_pos_r_nx;
      r_pos_c   <= w_pos_c_nx;
      r_stb     <= w_stb_nx;
    end
  end

  assign pos_row     = r_pos_r;
  assign pos_col     = r_pos_c;
  assign pos_stb     = r_stb;
  assign pos_valid   = (r_state == S_TRACK);
  assign pen_present = (r_state == S_TRACK);

endmodule

// File: tb/tb_pen_locator.sv
// tb/tb_pen_locator.sv - randomized bench for pen_locator against a frame-level model
module tb_pen_locator;

  localparam int HIT      = 8;
  localparam int BLANK    = 2;
  localparam int CONF     = 2;
  localparam int MISS     = 4;
  localparam int SLOT_LEN = 14;
  localparam int NSLOT    = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       pen_n = 1'b1;
  logic       frame_start = 1'b0;
  logic       slot_strobe = 1'b0;
  logic [2:0] slot_row = 3'd0;
  logic [2:0] slot_col = 3'd0;
  logic [2:0] pos_row, pos_col;
  logic       pos_valid, pos_stb, pen_present;

  pen_locator #(
    .HIT_CYCLES(HIT), .BLANK_CYCLES(BLANK), .CONFIRM_FRAMES(CONF), .MISS_FRAMES(MISS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pen_n(pen_n),
    .frame_start(frame_start), .slot_strobe(slot_strobe),
    .slot_row(slot_row), .slot_col(slot_col),
    .pos_row(pos_row), .pos_col(pos_col), .pos_valid(pos_valid),
    .pos_stb(pos_stb), .pen_present(pen_present)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int stb_seen = 0;
  bit chk_on = 0;

  // Model: per-cycle light history, slot bookkeeping, frame-level state
  bit hist [0:65535];
  int cyc = 0;
  int slot_start = -1;
  int slot_r = 0, slot_c = 0;
  bit fh = 0;
  int fh_r = 0, fh_c = 0;
  int mode = 0;              // 0 idle, 1 acquire, 2 track
  int cand_r = 0, cand_c = 0, conf = 0, miss = 0;
  int mpos_r = 0, mpos_c = 0;
  bit mvalid = 0, pend_stb = 0;
  int exp_row = 0, exp_col = 0;
  bit exp_valid = 0, exp_stb = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on && rst_n) begin
      check("pos_valid", pos_valid, exp_valid);
      check("pen_present", pen_present, exp_valid);
      check("pos_stb", pos_stb, exp_stb);
      check("pos_row", pos_row, exp_row);
      check("pos_col", pos_col, exp_col);
      if (pos_stb) stb_seen++;
    end
  end

  // Light is sensed two cycles after it is driven; a slot hits when HIT
  // consecutive lit cycles fit after the blanking window
  function automatic bit slot_hit(input int s0, input int s1);
    int run;
    bit h;
    run = 0;
    h = 0;
    for (int k = s0 + BLANK + 1; k < s1; k++) begin
      if (k >= 2 && hist[k-2]) run++;
      else run = 0;
      if (run >= HIT) h = 1;
    end
    return h;
  endfunction

  task automatic boundary();
    if (mode == 0) begin
      mode = 1; cand_r = 0; cand_c = 0; conf = 0; miss = 0;
    end else if (mode == 1) begin
      if (fh) begin
        if (fh_r == cand_r && fh_c == cand_c) conf = (conf < 15) ? conf + 1 : 15;
        else begin cand_r = fh_r; cand_c = fh_c; conf = 1; end
      end else begin
        conf = 0;
      end
      if (conf >= CONF) begin
        mpos_r = cand_r; mpos_c = cand_c; mvalid = 1; pend_stb = 1; mode = 2; miss = 0;
      end
    end else begin
      if (fh) begin
        miss = 0;
        if (fh_r != mpos_r || fh_c != mpos_c) begin
          mpos_r = fh_r; mpos_c = fh_c; pend_stb = 1;
        end
      end else begin
        miss = (miss < 15) ? miss + 1 : 15;
        if (miss >= MISS) begin mvalid = 0; conf = 0; mode = 1; end
      end
    end
  endtask

  task automatic tick(input bit fs, input bit ss, input int r, input int c, input bit pn, input bit e);
    @(posedge clk); #1;
    exp_valid = mvalid; exp_row = mpos_r; exp_col = mpos_c; exp_stb = pend_stb;
    pend_stb = 0;
    frame_start = fs; slot_strobe = ss; slot_row = 3'(r); slot_col = 3'(c);
    pen_n = pn; en = e;
    hist[cyc] = !pn;
    if (ss) begin
      if (slot_start >= 0 && !fh && slot_hit(slot_start, cyc)) begin
        fh = 1; fh_r = slot_r; fh_c = slot_c;
      end
      slot_start = cyc; slot_r = r; slot_c = c;
    end
    if (!e) begin
      mode = 0; mvalid = 0; cand_r = 0; cand_c = 0; conf = 0; miss = 0;
    end else if (fs) begin
      boundary();
    end
    if (fs) fh = 0;
    cyc++;
  endtask

  // kind: 0 qualifying pulse, 1 one cycle short, 2 random placement/length
  task automatic frame(input int p0r, input int p0c, input bit p0,
                       input int p1r, input int p1c, input bit p1,
                       input int kind, input int lo_from, input int lo_to);
    int pr[NSLOT];
    int pc[NSLOT];
    int fr, fcl, ps, pl, fi;
    bit lit, pn;
    for (int s = 0; s < NSLOT; s++) begin
      do begin
        fr = $urandom_range(7); fcl = $urandom_range(7);
      end while ((p0 && fr == p0r && fcl == p0c) || (p1 && fr == p1r && fcl == p1c));
      pr[s] = fr; pc[s] = fcl;
    end
    if (p0) begin pr[1] = p0r; pc[1] = p0c; end
    if (p1) begin pr[3] = p1r; pc[3] = p1c; end
    for (int s = 0; s < NSLOT; s++) begin
      lit = (p0 && pr[s] == p0r && pc[s] == p0c) || (p1 && pr[s] == p1r && pc[s] == p1c);
      if (kind == 0) begin ps = 1; pl = HIT; end
      else if (kind == 1) begin ps = 1; pl = HIT - 1; end
      else begin ps = $urandom_range(4); pl = $urandom_range(11, 4); end
      for (int k = 0; k < SLOT_LEN; k++) begin
        fi = s * SLOT_LEN + k;
        pn = !(lit && k >= ps && k < ps + pl);
        tick(s == 0 && k == 0, k == 0, pr[s], pc[s], pn, !(fi >= lo_from && fi < lo_to));
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); #2;
    rst_n = 0;
    #1;
    check("rst_pos_valid", pos_valid, 0);
    check("rst_pen_present", pen_present, 0);
    check("rst_pos_stb", pos_stb, 0);
    check("rst_pos_row", pos_row, 0);
    check("rst_pos_col", pos_col, 0);
    mode = 0; mvalid = 0; pend_stb = 0; mpos_r = 0; mpos_c = 0;
    cand_r = 0; cand_c = 0; conf = 0; miss = 0; fh = 0; slot_start = -1;
    exp_valid = 0; exp_stb = 0; exp_row = 0; exp_col = 0;
    #1;
    rst_n = 1;
  endtask

  initial begin
    int cr, cc, sel, kind, lf, lt;
    repeat (3) @(posedge clk);
    #1;
    check("reset_pos_valid", pos_valid, 0);
    check("reset_pos_row", pos_row, 0);
    rst_n = 1;
    chk_on = 1;

    // Hold pen on (3,5): arm, then publish at the second evaluated boundary
    stb_seen = 0;
    repeat (3) frame(3, 5, 1, 0, 0, 0, 0, -1, -1);
    check("t1_row", pos_row, 3);
    check("t1_col", pos_col, 5);
    check("t1_valid", pos_valid, 1);
    check("t1_present", pen_present, 1);
    check("t1_stb_count", stb_seen, 1);

    // Move to (3,6): one update strobe, then steady
    repeat (3) frame(3, 6, 1, 0, 0, 0, 0, -1, -1);
    check("t3_row", pos_row, 3);
    check("t3_col", pos_col, 6);
    check("t3_valid", pos_valid, 1);
    check("t3_stb_count", stb_seen, 2);

    // Pen removed: lost after the fourth hitless boundary, position retained
    repeat (5) frame(0, 0, 0, 0, 0, 0, 0, -1, -1);
    check("t4_valid", pos_valid, 0);
    check("t4_present", pen_present, 0);
    check("t4_row", pos_row, 3);
    check("t4_col", pos_col, 6);
    check("t4_stb_count", stb_seen, 2);

    // Two qualifying hits per frame: the earlier slot wins
    repeat (2) frame(2, 1, 1, 2, 2, 1, 0, -1, -1);
    frame(0, 0, 0, 0, 0, 0, 0, -1, -1);
    check("t5_row", pos_row, 2);
    check("t5_col", pos_col, 1);
    check("t5_valid", pos_valid, 1);

    // Reset mid-track clears everything at once; short pulses never qualify
    pulse_reset();
    stb_seen = 0;
    repeat (6) frame(1, 1, 1, 0, 0, 0, 1, -1, -1);
    check("t2_valid", pos_valid, 0);
    check("t2_stb_count", stb_seen, 0);

    // Enable drop mid-track, then re-acquire
    repeat (3) frame(4, 4, 1, 0, 0, 0, 0, -1, -1);
    check("t6_valid_before", pos_valid, 1);
    frame(4, 4, 1, 0, 0, 0, 0, 40, 50);
    check("t6_valid_dropped", pos_valid, 0);
    check("t6_row_held", pos_row, 4);
    repeat (2) frame(4, 4, 1, 0, 0, 0, 0, -1, -1);
    check("t6_not_yet", pos_valid, 0);
    frame(4, 4, 1, 0, 0, 0, 0, -1, -1);
    check("t6_reacquired", pos_valid, 1);
    check("t6_col", pos_col, 4);

    // Randomized traffic
    cr = $urandom_range(7);
    cc = $urandom_range(7);
    for (int f = 0; f < 60; f++) begin
      sel = $urandom_range(9);
      kind = ($urandom_range(3) == 0) ? 2 : $urandom_range(1) * 2;
      if ($urandom_range(11) == 0) begin
        lf = $urandom_range(80); lt = lf + $urandom_range(6, 1);
      end else begin
        lf = -1; lt = -1;
      end
      if (sel == 0) begin cr = $urandom_range(7); cc = $urandom_range(7); end
      if (f == 30) pulse_reset();
      if (sel == 1) frame(0, 0, 0, 0, 0, 0, kind, lf, lt);
      else if (sel == 2) frame(cr, cc, 1, $urandom_range(7), $urandom_range(7), 1, kind, lf, lt);
      else if (sel == 3) frame(cr, cc, 1, 0, 0, 0, 1, lf, lt);
      else frame(cr, cc, 1, 0, 0, 0, kind, lf, lt);
    end

    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pen_locator.md
# pen_locator

Light-pen position decoder for the 8x8 handwriting matrix. It watches the matrix scan, one lit pixel slot at a time, as reported by the LED scan logic, and correlates it with the raw light-pen sense input. It qualifies hits over consecutive frames and publishes a stable pen coordinate to the drawing and RAM-update logic. It is the sensing end of the scan/pen interface whose driving end is the matrix driver.

## Interface
Parameters:
- HIT_CYCLES, 8: consecutive pen-high cycles required inside one slot to register a hit (1..255).
- BLANK_CYCLES, 2: cycles after each slot strobe during which the pen is ignored; covers synchronizer and phototransistor lag.
- CONFIRM_FRAMES, 2: consecutive frames hitting the same pixel needed to acquire (1..15).
- MISS_FRAMES, 4: consecutive hitless frames in TRACK before the pen is declared lost (1..15).

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- en, input, 1: locate enable; driven high by the top level in DRAW/WRITE/ERASE.
- pen_n, input, 1: raw light-pen sense, asynchronous, active-low.
- frame_start, input, 1: one-cycle pulse marking the first slot of a frame; always coincides with slot_strobe.
- slot_strobe, input, 1: one-cycle pulse at the start of each pixel slot.
- slot_row, input, 3: row of the pixel lit in the new slot; sampled only when slot_strobe=1.
- slot_col, input, 3: column of the pixel lit in the new slot; sampled only when slot_strobe=1.
- pos_row, output, 3: published pen row.
- pos_col, output, 3: published pen column.
- pos_valid, output, 1: level; pos_row/pos_col hold a tracked position.
- pos_stb, output, 1: one-cycle pulse each time the published position is newly set or changed.
- pen_present, output, 1: high while in TRACK.

## Operation
- Pen input path: 2-FF synchronizer on pen_n, then inversion, giving pen=1 when light is sensed.
- Slot capture, on slot_strobe:
  - Latch slot_row/slot_col into cur_r/cur_c.
  - Clear the run counter and load the blank counter with BLANK_CYCLES.
- Run counter:
  - While blank is active, or pen=0, the run counter is 0.
  - Otherwise it increments, saturating at HIT_CYCLES.
  - The first time it reaches HIT_CYCLES in a slot, and frame_hit=0, set frame_hit=1 and hit_r/hit_c=cur_r/cur_c. The first hit in a frame wins; later hits in the same frame are ignored.
  - A slot_strobe cycle never registers a hit.
- Frame boundary (frame_start cycle): evaluate frame_hit/hit_r/hit_c from the ending frame, then clear frame_hit.
  - The first boundary after en rises, or after reset, only arms the block. That partial frame is discarded.
- FSM states: IDLE, ACQUIRE, TRACK.
  - IDLE: entered on reset or whenever en=0. Clears candidate, counters, pos_valid and pen_present. On the first frame_start with en=1, arm and go to ACQUIRE.
  - ACQUIRE, at each boundary:
    - hit equal to the candidate: confirm_cnt++.
    - hit differing from the candidate: candidate=hit, confirm_cnt=1.
    - no hit: confirm_cnt=0.
    - When confirm_cnt reaches CONFIRM_FRAMES: publish pos=candidate, pos_valid=1, pen_present=1, pos_stb pulse, go to TRACK, miss_cnt=0.
    - With CONFIRM_FRAMES=1, the first hit frame publishes.
  - TRACK, at each boundary:
    - hit: miss_cnt=0. If hit≠pos, update pos and pulse pos_stb. If hit==pos, no pulse.
    - no hit: miss_cnt++. At MISS_FRAMES: pos_valid=0, pen_present=0, confirm_cnt=0, go to ACQUIRE. pos_row/pos_col retain their last value. No pos_stb.
- en falling in any state: next cycle go to IDLE, pos_valid=0, pen_present=0. pos_row/pos_col hold.
- Counters confirm_cnt and miss_cnt are 4-bit and saturate; they never wrap. The run counter is 8-bit.

## Timing
- Reset values: pos_row=0, pos_col=0, pos_valid=0, pos_stb=0, pen_present=0. All internal counters 0; FSM in IDLE; disarmed.
- Hit latency: minimum BLANK_CYCLES+HIT_CYCLES cycles after slot_strobe, and 2 cycles of synchronizer delay after pen_n falls.
- Slot length must be ≥ BLANK_CYCLES+HIT_CYCLES+1 for a hit to be possible. This is a precondition, not checked.
- Boundary evaluation is done on the frame_start cycle. Registered results (pos_*, pos_valid, pen_present, pos_stb) appear in the cycle after frame_start. pos_stb is high for exactly that one cycle.
- slot_strobe arriving mid-run aborts the run; the partial count never carries into the next slot.
- frame_start while en=0 has no effect.
- rst_n low clears all state immediately (asynchronously). After rst_n releases, the block re-arms on the first boundary.

## Test plan
- Defaults. Pen held on pixel (3,5) for 3 frames after arming -> pos_stb once, at the 2nd evaluated boundary; pos=(3,5); pos_valid=1; pen_present=1.
- Pen-high pulse of 7 cycles after blanking in slot (1,1), repeated for 5 frames -> no hit; pos_valid stays 0; pos_stb never pulses.
- From TRACK at (3,5), move the pen to (3,6) for 1 frame -> one pos_stb; pos=(3,6); pos_valid stays 1. Staying at (3,6) further -> no further pos_stb.
- Pen removed in TRACK -> pos_valid and pen_present drop in the cycle after the 4th hitless boundary; pos stays (3,6); no pos_stb.
- Two qualifying hits in one frame, (2,1) then (2,2), for 2 frames -> publishes (2,1).
- Drop en, or pulse rst_n low, mid-TRACK:
  - en drop: pos_valid=0 the next cycle.
  - rst_n pulse: all outputs 0 immediately.
  - After re-enable, the first boundary only arms, and 2 further hit frames are needed to publish.
